seg7_io: RTL and testbench

Parametrised front-panel peripheral that supersedes the fixed 3-digit board interface. It drives a multiplexed 7-segment display with `DIGITS` digits and per-digit decimal point and blanking. It also samples `BUTTONS` push-buttons with synchronisation, optional debouncing and sticky press latches. It sits on the CPU 8-bit register bus as a generic IO slave and feeds the board's segment/select pins directly.

---
 rtl/seg7_io.sv | 230 +++++++++++++++++++++++
 tb/tb_seg7_io.sv | 267 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/seg7_io.sv
// Front-panel peripheral: multiplexed 7-segment display plus synchronised/debounced push-buttons on the 8-bit register bus.
// Latency: rd_data one cycle after addr; display outputs load on scan ticks; buttons reach STATE after 2 sync cycles (+DEB_TICKS scan ticks when debounced).
// Backpressure: none; the bus slave accepts a write every cycle and reads are side-effect free.
// Optional debouncer compiled in with `define SEG7_IO_DEBOUNCE_EN.
module seg7_io #(
  parameter int DIGITS      = 3,
  parameter int BUTTONS     = 5,
  parameter int SCAN_CYCLES = 50000,
  parameter int DEB_TICKS   = 4
) (
  input  logic               clk,
  input  logic               reset_n,
  input  logic [BUTTONS-1:0] buttons,
  output logic [7:0]         lcd_segment,
  output logic [DIGITS-1:0]  lcd_digit,
  input  logic [3:0]         addr,
  input  logic [7:0]         wr_data,
  input  logic               wr_en,
  output logic [7:0]         rd_data
);

  localparam int CW = $clog2(SCAN_CYCLES);
  localparam int IW = (DIGITS > 1) ? $clog2(DIGITS) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(SCAN_CYCLES - 1);
  localparam logic [IW-1:0] IDX_LAST = IW'(DIGITS - 1);

  // Digit register layout; the reserved bits are never written and read back as 0.
  typedef struct packed {
    logic       blank;
    logic [1:0] rsvd;
    logic       dp;
    logic [3:0] hex;
  } digit_t;

  localparam digit_t DIGIT_RST = '{blank: 1'b1, rsvd: 2'b00, dp: 1'b0, hex: 4'h0};

  // Elaboration-time parameter range checks.
  if (DIGITS < 1 || DIGITS > 8) begin : g_bad_digits
    $error("seg7_io: DIGITS must be 1..8");
  end
  if (BUTTONS < 1 || BUTTONS > 8) begin : g_bad_buttons
    $error("seg7_io: BUTTONS must be 1..8");
  end
  if (SCAN_CYCLES < 2) begin : g_bad_scan
    $error("seg7_io: SCAN_CYCLES must be at least 2");
  end
  if (DEB_TICKS < 1 || DEB_TICKS > 15) begin : g_bad_deb
    $error("seg7_io: DEB_TICKS must be 1..15");
  end

  // Active-low segment pattern for one digit register, blank overriding the decimal point.
  function automatic logic [7:0] seg_decode(input digit_t d);
    logic [7:0] s;
    case (d.hex)
      4'h0: s = 8'hC0;
      4'h1: s = 8'hF9;
      4'h2: s = 8'hA4;
      4'h3: s = 8'hB0;
      4'h4: s = 8'h99;
      4'h5: s = 8'h92;
      4'h6: s = 8'h82;
      4'h7: s = 8'hF8;
      4'h8: s = 8'h80;
      4'h9: s = 8'h90;
      4'hA: s = 8'h88;
      4'hB: s = 8'h83;
      4'hC: s = 8'hC6;
      4'hD: s = 8'hA1;
      4'hE: s = 8'h86;
      default: s = 8'h8E;
    endcase
    if (d.dp) s[7] = 1'b0;
    if (d.blank) s = 8'hFF;
    return s;
  endfunction

  logic [CW-1:0]      cnt;
  logic [IW-1:0]      idx;
  logic [IW-1:0]      idx_next;
  logic               scan_tick;
  logic               ctrl_en;
  digit_t             digit_q [DIGITS];
  digit_t             slot_dig;
  logic [DIGITS-1:0]  slot_sel;

  logic [BUTTONS-1:0] sync1;
  logic [BUTTONS-1:0] sync2;
  logic [BUTTONS-1:0] state;
  logic [BUTTONS-1:0] state_next;
  logic [BUTTONS-1:0] pressed;
  logic [BUTTONS-1:0] pressed_clr;
  logic [7:0]         rd_next;

  assign scan_tick = (cnt == CNT_LAST);
  assign idx_next  = (idx == IDX_LAST) ? '0 : idx + IW'(1);

  // Select and register contents of the slot that becomes visible at the next scan tick.
  always_comb begin
    slot_dig = DIGIT_RST;
    slot_sel = '0;
    for (int i = 0; i < DIGITS; i++) begin
      if (idx_next == IW'(i)) begin
        slot_dig    = digit_q[i];
        slot_sel[i] = 1'b1;
      end
    end
  end

  // Scan counter and registered display outputs; select and segments load together so they never disagree.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      cnt         <= '0;
      idx         <= IDX_LAST;
      lcd_digit   <= '0;
      lcd_segment <= 8'hFF;
    end else begin
      if (scan_tick) begin
        cnt <= '0;
        idx <= idx_next;
      end else begin
        cnt <= cnt + CW'(1);
      end
      if (!ctrl_en) begin
        lcd_digit   <= '0;
        lcd_segment <= 8'hFF;
      end else if (scan_tick) begin
        lcd_digit   <= slot_sel;
        lcd_segment <= seg_decode(slot_dig);
      end
    end
  end

  // CTRL and DIGIT register writes; reserved digit bits are masked off on the way in.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      ctrl_en <= 1'b1;
      for (int i = 0; i < DIGITS; i++) digit_q[i] <= DIGIT_RST;
    end else if (wr_en) begin
      if (addr == 4'h2) ctrl_en <= wr_data[0];
      for (int i = 0; i < DIGITS; i++) begin
        if (addr == 4'(8 + i)) digit_q[i] <= digit_t'(wr_data & 8'h9F);
      end
    end
  end

  // Two-flop synchroniser; idles high because the pins are active-low.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      sync1 <= '1;
      sync2 <= '1;
    end else begin
      sync1 <= buttons;
      sync2 <= sync1;
    end
  end

`ifdef SEG7_IO_DEBOUNCE_EN
  logic [BUTTONS-1:0] state_q;
  logic [BUTTONS-1:0] sample;
  logic [3:0]         deb_cnt [BUTTONS];

  assign sample = ~sync2;
  assign state  = state_q;

  // A button toggles once DEB_TICKS consecutive scan-tick samples disagree with its current state.
  always_comb begin
    state_next = state_q;
    for (int b = 0; b < BUTTONS; b++) begin
      if (scan_tick && (sample[b] != state_q[b]) && (deb_cnt[b] == 4'(DEB_TICKS - 1)))
        state_next[b] = ~state_q[b];
    end
  end

  // Debounced state and per-button run-length counters; an agreeing sample restarts the run.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q <= '0;
      for (int b = 0; b < BUTTONS; b++) deb_cnt[b] <= '0;
    end else begin
      state_q <= state_next;
      for (int b = 0; b < BUTTONS; b++) begin
        if (scan_tick) begin
          if ((sample[b] == state_q[b]) || (deb_cnt[b] == 4'(DEB_TICKS - 1)))
            deb_cnt[b] <= '0;
          else
            deb_cnt[b] <= deb_cnt[b] + 4'd1;
        end
      end
    end
  end
`else
  // Without debounce the second synchroniser flop is STATE, so its next value is the first flop.
  assign state      = ~sync2;
  assign state_next = ~sync1;
`endif

  // W1C mask for PRESSED, only during a write to its address.
  always_comb begin
    pressed_clr = '0;
    if (wr_en && (addr == 4'h1)) pressed_clr = wr_data[BUTTONS-1:0];
  end

  // Sticky press latches; a rising edge on the same edge as a clear wins.
  always_ff @(posedge clk) begin
    if (!reset_n) pressed <= '0;
    else          pressed <= (pressed & ~pressed_clr) | (state_next & ~state);
  end

  // Read multiplexer; unmapped addresses return zero.
  always_comb begin
    rd_next = '0;
    case (addr)
      4'h0: rd_next[BUTTONS-1:0] = state;
      4'h1: rd_next[BUTTONS-1:0] = pressed;
      4'h2: rd_next[0]           = ctrl_en;
      default: begin
        for (int i = 0; i < DIGITS; i++) begin
          if (addr == 4'(8 + i)) rd_next = digit_q[i];
        end
      end
    endcase
  end

  // Registered read data, refreshed every cycle.
  always_ff @(posedge clk) begin
    if (!reset_n) rd_data <= '0;
    else          rd_data <= rd_next;
  end

endmodule

// File: tb/tb_seg7_io.sv
// Directed bench for seg7_io with DIGITS=3, BUTTONS=5, SCAN_CYCLES=4, DEB_TICKS=4.
// Register accesses run from a vector table; scan, CTRL, button and reset corners are hand sequences.
// Debounce sequences apply when SEG7_IO_DEBOUNCE_EN is defined, otherwise the direct-sync ones.
module tb_seg7_io;
  localparam int DIGITS  = 3;
  localparam int BUTTONS = 5;

  logic               clk = 1'b0;
  logic               reset_n;
  logic [BUTTONS-1:0] buttons;
  logic [7:0]         lcd_segment;
  logic [DIGITS-1:0]  lcd_digit;
  logic [3:0]         addr;
  logic [7:0]         wr_data;
  logic               wr_en;
  logic [7:0]         rd_data;

  int n_checks = 0;
  int n_fail   = 0;

  typedef struct {
    logic [3:0] addr;
    logic       we;
    logic [7:0] wdata;
    logic [7:0] exp_rd;
  } vec_t;

  vec_t       vecs [12];
  logic [7:0] hex_pat [16];

  seg7_io #(
    .DIGITS(DIGITS), .BUTTONS(BUTTONS), .SCAN_CYCLES(4), .DEB_TICKS(4)
  ) dut (
    .clk(clk), .reset_n(reset_n), .buttons(buttons),
    .lcd_segment(lcd_segment), .lcd_digit(lcd_digit),
    .addr(addr), .wr_data(wr_data), .wr_en(wr_en), .rd_data(rd_data)
  );

  always #5 clk = ~clk;

  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Advance until digit 0 is freshly selected; bounded so a stuck scan still finishes.
  task automatic wait_digit0(input string name);
    logic [DIGITS-1:0] prev;
    bit found;
    found = 1'b0;
    prev  = lcd_digit;
    for (int i = 0; i < 24 && !found; i++) begin
      step(1);
      if (lcd_digit == 3'b001 && prev != 3'b001) found = 1'b1;
      prev = lcd_digit;
    end
    check({name, "_sync"}, 32'(found), 32'd1);
  endtask

  task automatic bus_write(input logic [3:0] a, input logic [7:0] d);
    addr = a; wr_data = d; wr_en = 1'b1;
    step(1);
    wr_en = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    logic [DIGITS-1:0] exp_dig;
    logic [7:0]        exp_seg;
    logic [3:0]        h;

    hex_pat = '{8'hC0, 8'hF9, 8'hA4, 8'hB0, 8'h99, 8'h92, 8'h82, 8'hF8,
                8'h80, 8'h90, 8'h88, 8'h83, 8'hC6, 8'hA1, 8'h86, 8'h8E};
    vecs[0]  = '{4'h9, 1'b1, 8'h1A, 8'h80};
    vecs[1]  = '{4'hA, 1'b1, 8'hFF, 8'h80};
    vecs[2]  = '{4'h8, 1'b0, 8'h00, 8'h05};
    vecs[3]  = '{4'h9, 1'b0, 8'h00, 8'h1A};
    vecs[4]  = '{4'hA, 1'b0, 8'h00, 8'h9F};
    vecs[5]  = '{4'hB, 1'b1, 8'h55, 8'h00};
    vecs[6]  = '{4'hB, 1'b0, 8'h00, 8'h00};
    vecs[7]  = '{4'h2, 1'b0, 8'h00, 8'h01};
    vecs[8]  = '{4'h3, 1'b1, 8'hFF, 8'h00};
    vecs[9]  = '{4'h0, 1'b0, 8'h00, 8'h00};
    vecs[10] = '{4'h1, 1'b0, 8'h00, 8'h00};
    vecs[11] = '{4'hF, 1'b0, 8'h00, 8'h00};

    reset_n = 1'b0; buttons = '1; addr = 4'h0; wr_data = 8'h00; wr_en = 1'b0;
    step(3);
    check("rst_seg", lcd_segment, 8'hFF);
    check("rst_dig", lcd_digit, 3'b000);
    check("rst_rd", rd_data, 8'h00);

    // Free-running scan with all digits blank: 001,010,100 each for 4 cycles.
    reset_n = 1'b1;
    step(3);
    check("scan_pre_tick", lcd_digit, 3'b000);
    for (int k = 0; k < 12; k++) begin
      step(1);
      exp_dig = 3'b001 << ((k / 4) % 3);
      check($sformatf("scan_dig_%0d", k), lcd_digit, exp_dig);
      check($sformatf("scan_seg_%0d", k), lcd_segment, 8'hFF);
    end

    // Write digit 0 on a scan-tick edge: the slot loaded there still shows the old (blank) value.
    addr = 4'h8; wr_data = 8'h05; wr_en = 1'b1;
    step(1);
    wr_en = 1'b0;
    check("tickwr_dig", lcd_digit, 3'b001);
    check("tickwr_seg", lcd_segment, 8'hFF);
    check("tickwr_rd_old", rd_data, 8'h80);

    for (int i = 0; i < 12; i++) begin
      addr = vecs[i].addr; wr_data = vecs[i].wdata; wr_en = vecs[i].we;
      step(1);
      wr_en = 1'b0;
      check($sformatf("reg_vec%0d", i), rd_data, vecs[i].exp_rd);
    end

    // Display contents: 05 -> 92, 1A -> 08 (dp), 9F -> FF (blank suppresses dp).
    wait_digit0("disp");
    for (int k = 0; k < 12; k++) begin
      if (k > 0) step(1);
      case (k / 4)
        0: begin exp_dig = 3'b001; exp_seg = 8'h92; end
        1: begin exp_dig = 3'b010; exp_seg = 8'h08; end
        default: begin exp_dig = 3'b100; exp_seg = 8'hFF; end
      endcase
      check($sformatf("disp_dig_%0d", k), lcd_digit, exp_dig);
      check($sformatf("disp_seg_%0d", k), lcd_segment, exp_seg);
    end

    // CTRL disable/enable keeps the counter phase.
    step(1);
    check("ctrl_tick_dig", lcd_digit, 3'b001);
    bus_write(4'h2, 8'h00);
    check("ctrl_off_edge", lcd_digit, 3'b001);
    step(1);
    check("ctrl_off_dig", lcd_digit, 3'b000);
    check("ctrl_off_seg", lcd_segment, 8'hFF);
    step(4);
    check("ctrl_off_hold", lcd_digit, 3'b000);
    bus_write(4'h2, 8'h01);
    check("ctrl_on_wait", lcd_digit, 3'b000);
    step(1);
    check("ctrl_resume_dig", lcd_digit, 3'b100);
    step(4);
    check("ctrl_resume_dig0", lcd_digit, 3'b001);
    check("ctrl_resume_seg0", lcd_segment, 8'h92);

    // All sixteen hex patterns on digit 0, decimal point on for odd values.
    for (int v = 0; v < 16; v++) begin
      h = 4'(v);
      bus_write(4'h8, {3'b000, h[0], h});
      wait_digit0($sformatf("hex%0d", v));
      exp_seg = hex_pat[v];
      if (h[0]) exp_seg[7] = 1'b0;
      check($sformatf("hex_seg_%0d", v), lcd_segment, exp_seg);
    end

`ifdef SEG7_IO_DEBOUNCE_EN
    // Glitch of 3 scan ticks is rejected.
    addr = 4'h0;
    buttons[2] = 1'b0;
    step(12);
    buttons[2] = 1'b1;
    step(30);
    check("deb_glitch_state", rd_data, 8'h00);
    addr = 4'h1;
    step(1);
    check("deb_glitch_pressed", rd_data, 8'h00);
    // A long press is accepted.
    addr = 4'h0;
    buttons[2] = 1'b0;
    step(24);
    check("deb_hold_state", rd_data, 8'h04);
    addr = 4'h1;
    step(1);
    check("deb_hold_pressed", rd_data, 8'h04);
    buttons[2] = 1'b1;
    step(30);
    bus_write(4'h1, 8'h04);
    step(1);
    check("deb_w1c", rd_data, 8'h00);
`else
    // STATE follows the pin two cycles after it changes; rd_data adds its own cycle.
    addr = 4'h0;
    step(1);
    buttons[0] = 1'b0;
    step(2);
    check("sync_state_early", rd_data, 8'h00);
    step(1);
    check("sync_state", rd_data, 8'h01);
    addr = 4'h1;
    step(1);
    check("sync_pressed", rd_data, 8'h01);
    buttons[0] = 1'b1;
    step(3);
    bus_write(4'h1, 8'h01);
    step(1);
    check("w1c_clear", rd_data, 8'h00);
    // New press whose rising edge lands on the W1C edge: set wins.
    buttons[0] = 1'b0;
    step(1);
    bus_write(4'h1, 8'h01);
    step(1);
    check("w1c_collision", rd_data, 8'h01);
    // Several buttons at once, then a partial clear.
    buttons = 5'b01010;
    addr = 4'h0;
    step(3);
    check("multi_state", rd_data, 8'h15);
    addr = 4'h1;
    step(1);
    check("multi_pressed", rd_data, 8'h15);
    bus_write(4'h1, 8'h04);
    step(1);
    check("partial_w1c", rd_data, 8'h11);
    buttons = '1;
    step(3);
    addr = 4'h0;
    step(1);
    check("release_state", rd_data, 8'h00);
`endif

    // Reset mid-scan returns everything to reset values on the next edge.
    addr = 4'h8;
    step(2);
    check("pre_rst_rd", rd_data, 8'h1F);
    reset_n = 1'b0;
    step(1);
    check("midrst_seg", lcd_segment, 8'hFF);
    check("midrst_dig", lcd_digit, 3'b000);
    check("midrst_rd", rd_data, 8'h00);
    reset_n = 1'b1;
    step(1);
    check("midrst_digit0_reg", rd_data, 8'h80);
    addr = 4'h1;
    step(1);
    check("midrst_pressed", rd_data, 8'h00);
    addr = 4'h2;
    step(1);
    check("midrst_ctrl", rd_data, 8'h01);
    check("midrst_pre_tick", lcd_digit, 3'b000);
    step(1);
    check("midrst_first_tick_dig", lcd_digit, 3'b001);
    check("midrst_first_tick_seg", lcd_segment, 8'hFF);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
